// File: rtl/sd_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_buf_pkg
// Description : Shared constants, width helpers and the sector-receive state
//               type for the SD sector buffering logic.
// Contents    : SD_DEPTH_DEFAULT - default words per sector buffer
//               SD_NUM_BANKS     - ping-pong banks per channel
//               SD_BANK_W        - width of a bank selector
//               sd_addr_w()      - word-index width for a given depth
//               sd_ch_w()        - channel-select width (at least 1)
//               sec_state_e      - sector receive state
// Revision    : 1.0 - initial release
// ============================================================================
package sd_buf_pkg;

    localparam int SD_DEPTH_DEFAULT = 512;
    localparam int SD_NUM_BANKS     = 2;
    localparam int SD_BANK_W        = $clog2(SD_NUM_BANKS);

    function automatic int sd_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int sd_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // IDLE: no sector open, stray words are discarded.
    // RECV: sector open and being stored.
    // DROP: sector open but its channel was full at word 0; discard to end.
    typedef enum logic [1:0] {
        SEC_IDLE = 2'd0,
        SEC_RECV = 2'd1,
        SEC_DROP = 2'd2
    } sec_state_e;

endpackage
`default_nettype wire

// File: rtl/sd_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : sd_bank_ram
// Description : Simple dual-port RAM holding every channel's ping-pong banks.
//               One write port, one read port with a registered output that
//               holds its value when no read is requested. Only the output
//               register is reset; the array contents survive reset.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset (output reg only)
//               wr_en    - write strobe
//               wr_addr  - write address {channel, bank, index}
//               wr_data  - write data
//               rd_en    - read strobe
//               rd_addr  - read address {channel, bank, index}
//               rd_data  - registered read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sd_bank_ram #(
    parameter int DW    = 8,
    parameter int WORDS = 3072,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_sector_router.sv
`default_nettype none
// ============================================================================
// Module      : sd_sector_router
// Description : Routes SD byte-stream sectors into per-channel ping-pong
//               buffers. The channel is chosen at word 0 of each sector; a
//               sector aimed at a channel whose two banks are both full is
//               dropped and flagged. Readers consume the oldest full bank of a
//               channel and free it with rd_release.
// Ports       : sys_clk        - clock, rising edge
//               sys_rst        - asynchronous active-high reset
//               sd_outdata_en  - write strobe from the SD reader
//               sd_outdata     - write data
//               sd_outdata_num - word index within the sector
//               ch_sel         - destination channel (sampled at word 0)
//               rd_ch          - channel to read / release
//               rd_en          - read strobe
//               rd_addr        - read word index
//               rd_data        - read data, one cycle after rd_en
//               rd_release     - frees the oldest full bank of rd_ch
//               bank_ready     - per channel: at least one full bank
//               overflow_err   - sticky: a sector was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sector_router
    import sd_buf_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DW     = 8,
    parameter int DEPTH  = SD_DEPTH_DEFAULT,
    localparam int AW    = sd_addr_w(DEPTH),
    localparam int CW    = sd_ch_w(NUM_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sd_outdata_en,
    input  logic [DW-1:0]     sd_outdata,
    input  logic [AW-1:0]     sd_outdata_num,
    input  logic [CW-1:0]     ch_sel,
    input  logic [CW-1:0]     rd_ch,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    input  logic              rd_release,
    output logic [NUM_CH-1:0] bank_ready,
    output logic              overflow_err
);

    localparam int RAM_AW    = CW + SD_BANK_W + AW;
    localparam int RAM_WORDS = NUM_CH * SD_NUM_BANKS * DEPTH;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    sec_state_e        state;
    logic [CW-1:0]     cur_ch;
    logic [NUM_CH-1:0] wr_ptr;
    logic [NUM_CH-1:0] rd_ptr;
    logic [1:0]        count [NUM_CH];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                 first_word;
    logic                 last_word;
    logic                 sel_valid;
    logic                 sel_full;
    logic                 sel_wbank;
    logic                 cur_wbank;
    logic                 rd_valid;
    logic                 rd_bank;
    logic                 rd_has_data;
    logic                 wr_accept;
    logic [CW-1:0]        wr_ch;
    logic                 wr_bank;
    logic [NUM_CH-1:0]    complete_vec;
    logic [NUM_CH-1:0]    release_vec;
    logic [RAM_AW-1:0]    ram_wr_addr;
    logic [RAM_AW-1:0]    ram_rd_addr;
    logic                 ram_rd_en;

    // Per-channel lookups are done by loop compare so that an out-of-range
    // channel number (possible when NUM_CH is not a power of two) simply
    // matches nothing instead of indexing past the arrays.
    always_comb begin
        first_word   = (sd_outdata_num == '0);
        last_word    = (sd_outdata_num == AW'(DEPTH - 1));
        sel_valid    = 1'b0;
        sel_full     = 1'b0;
        sel_wbank    = 1'b0;
        cur_wbank    = 1'b0;
        rd_valid     = 1'b0;
        rd_bank      = 1'b0;
        rd_has_data  = 1'b0;
        wr_accept    = 1'b0;
        wr_ch        = cur_ch;
        wr_bank      = 1'b0;
        complete_vec = '0;
        release_vec  = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CW'(i)) begin
                sel_valid = 1'b1;
                sel_full  = (count[i] == 2'd2);
                sel_wbank = wr_ptr[i];
            end
            if (cur_ch == CW'(i)) begin
                cur_wbank = wr_ptr[i];
            end
            if (rd_ch == CW'(i)) begin
                rd_valid    = 1'b1;
                rd_bank     = rd_ptr[i];
                rd_has_data = (count[i] != 2'd0);
            end
        end

        // Word 0 decides routing from the live ch_sel; later words follow
        // the channel latched at word 0.
        if (first_word) begin
            wr_ch     = ch_sel;
            wr_bank   = sel_wbank;
            wr_accept = sd_outdata_en && sel_valid && !sel_full;
        end else begin
            wr_ch     = cur_ch;
            wr_bank   = cur_wbank;
            wr_accept = sd_outdata_en && (state == SEC_RECV);
        end

        for (int i = 0; i < NUM_CH; i++) begin
            complete_vec[i] = wr_accept && last_word && (wr_ch == CW'(i));
            release_vec[i]  = rd_release && rd_has_data && (rd_ch == CW'(i));
        end

        ram_wr_addr = {wr_ch, wr_bank, sd_outdata_num};
        ram_rd_addr = {rd_ch, rd_bank, rd_addr};
        ram_rd_en   = rd_en && rd_valid;
    end

    // ------------------------------------------------------------------
    // Sector state machine and bank bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= SEC_IDLE;
            cur_ch       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= 2'd0;
            end
        end else begin
            if (sd_outdata_en) begin
                if (first_word) begin
                    cur_ch <= ch_sel;
                    if (!sel_valid) begin
                        // Nonexistent channel: the sector is not opened, so
                        // its remaining words fall into the stray-word path.
                        state <= SEC_IDLE;
                    end else if (sel_full) begin
                        state        <= SEC_DROP;
                        overflow_err <= 1'b1;
                    end else begin
                        state <= SEC_RECV;
                    end
                end else if (last_word) begin
                    state <= SEC_IDLE;
                end
            end

            // Completion and release in the same cycle cancel in the count
            // but each still moves its own pointer.
            for (int i = 0; i < NUM_CH; i++) begin
                case ({complete_vec[i], release_vec[i]})
                    2'b10:   count[i] <= count[i] + 2'd1;
                    2'b01:   count[i] <= count[i] - 2'd1;
                    default: count[i] <= count[i];
                endcase
                if (complete_vec[i]) begin
                    wr_ptr[i] <= ~wr_ptr[i];
                end
                if (release_vec[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ready
            assign bank_ready[g] = (count[g] != 2'd0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bank storage
    // ------------------------------------------------------------------
    sd_bank_ram #(
        .DW     (DW),
        .WORDS  (RAM_WORDS),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (wr_accept),
        .wr_addr (ram_wr_addr),
        .wr_data (sd_outdata),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (rd_data)
    );

endmodule
`default_nettype wire
